block_transfer_sequencer: RTL and testbench

Sequences one 128-bit block operation on the cp2 block engine. It drains WORDS input words from the word FIFO and packs them into a block. It starts the engine, waits for completion with a timeout, then unpacks the result block into the output word FIFO. It replaces ad-hoc glue around the word/block converters with a single FSM that owns both FIFO handshakes and the engine start/done handshake.

---
 rtl/block_transfer_sequencer.sv | 143 ++++++++++++++
 tb/tb_block_transfer_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_transfer_sequencer.sv
// Purpose: gathers WORDS input words into one block, runs the block engine once, and scatters the result to the output FIFO.
// Latency: 2*WORDS + L + 2 cycles per block with no stalls (L = engine start-to-done cycles); aborts after TIMEOUT wait cycles.
// Backpressure: in_empty stalls GATHER and out_full stalls DRAIN one cycle each, with no timeout and without advancing idx.
module block_transfer_sequencer #(
  parameter int WSIZE   = 32,
  parameter int WORDS   = 4,
  parameter int TIMEOUT = 256,
  parameter int CNTW    = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     enable,
  input  logic                     clear_err,
  input  logic [WSIZE-1:0]         in_data,
  input  logic                     in_empty,
  output logic                     in_read_en,
  output logic [WSIZE*WORDS-1:0]   eng_block_in,
  output logic                     eng_start,
  input  logic                     eng_done,
  input  logic [WSIZE*WORDS-1:0]   eng_block_out,
  input  logic                     out_full,
  output logic                     out_write_en,
  output logic [WSIZE-1:0]         out_data,
  output logic                     busy,
  output logic [CNTW-1:0]          block_count,
  output logic                     timeout_err
);

  localparam int BSIZE = WSIZE * WORDS;
  localparam int IW    = $clog2(WORDS + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GATHER,
    S_START,
    S_WAIT,
    S_DRAIN
  } state_t;

  state_t           state;
  logic [IW-1:0]    idx;
  logic [TW-1:0]    timer;
  logic [BSIZE-1:0] block_q;
  logic [BSIZE-1:0] result_q;

  // FIFO strobes are pure decodes of state and the FIFO flags so a pop/push lands on the same edge that consumes it
  assign in_read_en   = (state == S_GATHER) && !in_empty;
  assign out_write_en = (state == S_DRAIN) && !out_full;
  assign eng_block_in = block_q;

  // Select result word idx, word 0 sitting in the MSBs
  always_comb begin
    out_data = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx == IW'(i)) out_data = result_q[(WORDS-1-i)*WSIZE +: WSIZE];
    end
  end

  // Sequencer FSM: owns gather/pack, engine start/done handshake with timeout, unpack/drain, and status
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      idx         <= '0;
      timer       <= '0;
      block_q     <= '0;
      result_q    <= '0;
      eng_start   <= 1'b0;
      busy        <= 1'b0;
      block_count <= '0;
      timeout_err <= 1'b0;
    end else begin
      // A timeout later in this block overrides the clear, so a fresh error is never lost
      if (clear_err) timeout_err <= 1'b0;

      case (state)
        S_IDLE: begin
          if (enable) begin
            state <= S_GATHER;
            idx   <= '0;
            busy  <= 1'b1;
          end
        end

        S_GATHER: begin
          if (!in_empty) begin
            for (int i = 0; i < WORDS; i++) begin
              if (idx == IW'(i)) block_q[(WORDS-1-i)*WSIZE +: WSIZE] <= in_data;
            end
            if (idx == IW'(WORDS - 1)) begin
              idx       <= '0;
              state     <= S_START;
              eng_start <= 1'b1;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        S_START: begin
          eng_start <= 1'b0;
          timer     <= '0;
          state     <= S_WAIT;
        end

        S_WAIT: begin
          // The last wait cycle aborts even if done arrives in it: done at S+TIMEOUT is too late
          if (timer == TW'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            timer       <= '0;
            state       <= S_IDLE;
            busy        <= 1'b0;
          end else if (eng_done) begin
            result_q <= eng_block_out;
            idx      <= '0;
            state    <= S_DRAIN;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_DRAIN: begin
          if (!out_full) begin
            if (idx == IW'(WORDS - 1)) begin
              idx         <= '0;
              block_count <= block_count + CNTW'(1);
              state       <= S_IDLE;
              busy        <= 1'b0;
            end else begin
              idx <= idx + IW'(1);
            end
          end
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_transfer_sequencer.sv
// Purpose: bench for block_transfer_sequencer with FIFO and echoing-engine models plus a decoupled scoreboard monitor.
// Latency: exact block periods are checked against 2*WORDS + L + 2 plus stall cycles.
// Backpressure: input stalls and output-full windows are injected by the FIFO models on demand.
module tb_block_transfer_sequencer;

  logic         clock;
  logic         reset_n;
  logic         enable;
  logic         clear_err;
  logic [31:0]  in_data;
  logic         in_empty;
  logic         in_read_en;
  logic [127:0] eng_block_in;
  logic         eng_start;
  logic         eng_done;
  logic [127:0] eng_block_out;
  logic         out_full;
  logic         out_write_en;
  logic [31:0]  out_data;
  logic         busy;
  logic [1:0]   block_count;
  logic         timeout_err;

  block_transfer_sequencer #(
    .WSIZE(32), .WORDS(4), .TIMEOUT(8), .CNTW(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .clear_err(clear_err),
    .in_data(in_data), .in_empty(in_empty), .in_read_en(in_read_en),
    .eng_block_in(eng_block_in), .eng_start(eng_start), .eng_done(eng_done),
    .eng_block_out(eng_block_out), .out_full(out_full), .out_write_en(out_write_en),
    .out_data(out_data), .busy(busy), .block_count(block_count), .timeout_err(timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  // Scoreboard queues and model state
  logic [31:0]  in_q[$];
  logic [31:0]  exp_out[$];
  logic [127:0] exp_blk[$];
  logic [127:0] eng_hold;
  bit pop_flag = 0, wr_flag = 0, start_flag = 0, spur_req = 0;
  int in_pops = 0, out_writes = 0, starts = 0;
  int stall_at = -1, stall_len = 0, stall_left = 0;
  int full_at = -1, full_len = 0, full_left = 0;
  int eng_lat = 1, eng_cnt = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // FIFO and engine models: apply the strobes sampled at the previous negedge, then drive new inputs
  initial begin
    in_empty = 1'b1; in_data = '0; out_full = 1'b0; eng_done = 1'b0; eng_block_out = '0;
    forever begin
      @(posedge clock); #1;
      if (stall_left > 0) stall_left--;
      if (pop_flag) begin
        if (in_q.size() != 0) void'(in_q.pop_front());
        in_pops++;
        if (in_pops == stall_at) begin stall_left = stall_len; stall_at = -1; end
      end
      if (full_left > 0) full_left--;
      if (wr_flag) begin
        out_writes++;
        if (out_writes == full_at) begin full_left = full_len; full_at = -1; end
      end
      eng_done = 1'b0;
      if (start_flag) eng_cnt = eng_lat;
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) begin eng_done = 1'b1; eng_block_out = eng_hold; end
      end
      if (spur_req) begin eng_done = 1'b1; eng_block_out = {4{32'hDEADBEEF}}; spur_req = 0; end
      in_empty = (in_q.size() == 0) || (stall_left > 0);
      in_data  = (in_q.size() != 0) ? in_q[0] : 32'h0;
      out_full = (full_left > 0);
    end
  end

  // Monitor: samples strobes mid-cycle, checks FIFO protocol and pops the scoreboard
  initial begin
    forever begin
      @(negedge clock);
      pop_flag   = in_read_en;
      wr_flag    = out_write_en;
      start_flag = eng_start;
      if (in_read_en) chk("rd_when_empty", in_empty, 0);
      if (out_write_en) begin
        chk("wr_when_full", out_full, 0);
        if (exp_out.size() == 0) chk("unexpected_write", out_data, 'x);
        else chk("out_word", out_data, exp_out.pop_front());
      end
      if (eng_start) begin
        starts++;
        eng_hold = eng_block_in;
        if (exp_blk.size() == 0) chk("unexpected_start", eng_block_in, 'x);
        else chk("eng_block_in", eng_block_in, exp_blk.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_zero(input string nm);
    chk({nm, "_in_read_en"}, in_read_en, 0);
    chk({nm, "_eng_start"}, eng_start, 0);
    chk({nm, "_eng_block_in"}, eng_block_in, 0);
    chk({nm, "_out_write_en"}, out_write_en, 0);
    chk({nm, "_out_data"}, out_data, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_block_count"}, block_count, 0);
    chk({nm, "_timeout_err"}, timeout_err, 0);
  endtask

  // Queue one block into the input FIFO; nout words of it are expected back from the echo engine
  task automatic push_block(input logic [127:0] blk, input int nout, input int lat);
    for (int i = 0; i < 4; i++) in_q.push_back(blk[127-32*i -: 32]);
    for (int i = 0; i < nout; i++) exp_out.push_back(blk[127-32*i -: 32]);
    exp_blk.push_back(blk);
    eng_lat = lat;
    @(posedge clock); #2;
  endtask

  // Pulse enable in cycle 0 and require IDLE to return exactly in cycle n
  task automatic run_block(input string nm, input int n, input logic [1:0] cnt);
    enable = 1'b1;
    @(posedge clock); #2 enable = 1'b0;
    repeat (n - 2) @(posedge clock);
    @(negedge clock);
    chk({nm, "_busy_before_end"}, busy, 1);
    @(negedge clock);
    chk({nm, "_busy_at_end"}, busy, 0);
    chk({nm, "_block_count"}, block_count, cnt);
    chk({nm, "_all_words_out"}, exp_out.size(), 0);
  endtask

  // Engine answers at S+8: one cycle too late, so the block must abort at the edge ending S+8
  task automatic run_timeout(input string nm, input bit clr_at_abort, input bit err_before);
    enable = 1'b1;
    @(posedge clock); #2 enable = 1'b0;
    repeat (12) @(posedge clock);
    #2 clear_err = clr_at_abort;
    @(negedge clock);
    chk({nm, "_busy_last_wait"}, busy, 1);
    chk({nm, "_err_last_wait"}, timeout_err, err_before);
    @(posedge clock); #2 clear_err = 1'b0;
    @(negedge clock);
    chk({nm, "_busy_after_abort"}, busy, 0);
    chk({nm, "_err_after_abort"}, timeout_err, 1);
    chk({nm, "_count_unchanged"}, block_count, 2'd3);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; enable = 1'b0; clear_err = 1'b0;
    repeat (2) @(negedge clock);
    chk_zero("reset");
    @(posedge clock); #2 reset_n = 1'b1;

    // Basic: L=3, period 2*4+3+2 = 13
    push_block(128'h11111111_22222222_33333333_44444444, 4, 3);
    run_block("basic", 13, 2'd1);

    // Input stall of 5 cycles after two pops: 13 + 5
    push_block(128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3, 4, 3);
    stall_at = in_pops + 2; stall_len = 5;
    run_block("in_stall", 18, 2'd2);

    // Output full for 3 cycles while idx=2: 13 + 3
    push_block(128'h01234567_89ABCDEF_FEDCBA98_76543210, 4, 3);
    full_at = out_writes + 2; full_len = 3;
    run_block("out_full", 16, 2'd3);

    // Timeout, then a second timeout with clear_err raised in the abort cycle (timeout wins)
    push_block(128'h55555555_66666666_77777777_88888888, 0, 8);
    run_timeout("timeout1", 1'b0, 1'b0);
    push_block(128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC, 0, 8);
    run_timeout("timeout2", 1'b1, 1'b1);
    @(posedge clock); #2 clear_err = 1'b1;
    @(posedge clock); #2 clear_err = 1'b0;
    @(negedge clock);
    chk("clear_err", timeout_err, 0);

    // Normal block after the timeouts, L=2: period 12, count wraps 3 -> 0
    @(posedge clock); #2;
    push_block(128'hCAFEF00D_0BADBEEF_13572468_2468ACE0, 4, 2);
    run_block("after_timeout", 12, 2'd0);

    // Reset mid-DRAIN: L=1 puts DRAIN in cycles 7..10; reset in cycle 9 after two writes
    @(posedge clock); #2;
    push_block(128'hF0000001_F0000002_F0000003_F0000004, 2, 1);
    enable = 1'b1;
    @(posedge clock); #2 enable = 1'b0;
    repeat (8) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk_zero("mid_drain_reset");
    chk("two_writes_before_reset", exp_out.size(), 0);
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock); #2;
    push_block(128'h0A0A0A0A_1B1B1B1B_2C2C2C2C_3D3D3D3D, 4, 1);
    run_block("post_reset", 11, 2'd1);

    // Three back-to-back blocks with enable held; spurious done during the first GATHER
    @(posedge clock); #2;
    push_block(128'h00000001_00000002_00000003_00000004, 4, 2);
    push_block(128'h00000010_00000020_00000030_00000040, 4, 2);
    push_block(128'h00000100_00000200_00000300_00000400, 4, 2);
    enable = 1'b1;
    @(posedge clock); #2;
    spur_req = 1;
    n = 0;
    while (in_q.size() != 0 && n < 200) begin @(posedge clock); #2; n++; end
    chk("b2b_input_drained", n < 200, 1);
    enable = 1'b0;
    n = 0;
    @(negedge clock);
    while ((busy || exp_out.size() != 0) && n < 200) begin @(negedge clock); n++; end
    chk("b2b_completed", n < 200, 1);
    chk("b2b_block_count_wrap", block_count, 2'd0);

    // 11 blocks started in total, 44 words popped
    chk("all_blocks_started", exp_blk.size(), 0);
    chk("total_starts", starts, 11);
    chk("total_pops", in_pops, 44);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
